// File: rtl/gf_inv.sv
// gf_inv -- sequential GF(2^8) multiplicative inverter, out = in^254.
//
// A single bit-serial multiplier (MSB-first Horner, one bit per cycle) is
// time-shared by square-and-multiply: seven rounds of (square base,
// multiply result by base) build a^(2+4+...+128) = a^254. The latency is
// fixed at 112 cycles from accept to out_valid, and does not depend on the data.
//
// Parameters
//   POLY      low 8 bits of the field polynomial (x^8 implied), AES = 8'h1B
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand valid
//   in_ready  block idle and able to accept an operand
//   in_data   operand a
//   out_valid result valid (held until out_ready)
//   out_ready consumer accepts out_data
//   out_data  a^-1 (0x00 for a = 0x00); holds its value after the handshake
//   busy      computation in progress
module gf_inv #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQR  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] base_q, base_d;
    logic [7:0] res_q, res_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] out_data_q, out_data_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [2:0] round_q, round_d;

    logic [7:0] mc;
    logic [7:0] acc_step;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
    endfunction

    // Shared multiplier: the multiplier operand is always base; the
    // multiplicand is base when squaring, res when multiplying.
    always_comb begin
        mc       = (state_q == S_MUL) ? res_q : base_q;
        acc_step = xtime(acc_q) ^ (base_q[bitcnt_q] ? mc : 8'h00);
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        res_d      = res_q;
        acc_d      = acc_q;
        bitcnt_d   = bitcnt_q;
        round_d    = round_q;
        out_data_d = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    base_d   = in_data;
                    res_d    = 8'h01;
                    round_d  = '0;
                    acc_d    = '0;
                    bitcnt_d = 3'd7;
                    state_d  = S_SQR;
                end
            end
            S_SQR: begin
                acc_d    = acc_step;
                bitcnt_d = bitcnt_q - 3'd1;
                if (bitcnt_q == 3'd0) begin
                    base_d   = acc_step;
                    acc_d    = '0;
                    bitcnt_d = 3'd7;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                bitcnt_d = bitcnt_q - 3'd1;
                if (bitcnt_q == 3'd0) begin
                    res_d    = acc_step;
                    acc_d    = '0;
                    bitcnt_d = 3'd7;
                    if (round_q == 3'd6) begin
                        out_data_d = acc_step;
                        state_d    = S_DONE;
                    end else begin
                        round_d = round_q + 3'd1;
                        state_d = S_SQR;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            res_q      <= '0;
            acc_q      <= '0;
            bitcnt_q   <= '0;
            round_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            res_q      <= res_d;
            acc_q      <= acc_d;
            bitcnt_q   <= bitcnt_d;
            round_q    <= round_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_SQR) || (state_q == S_MUL);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_gf_inv.sv
// Testbench for gf_inv: scoreboard of expected inverses, fixed-latency and
// handshake checks, asynchronous reset abort, exhaustive sweep.
module tb_gf_inv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];

    localparam int LAT = 112;

    gf_inv #(.POLY(8'h1B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference GF(2^8) multiply, AES polynomial, LSB-first shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Inverse by exhaustive search (0 maps to 0).
    function automatic logic [7:0] gf_inv_model(input logic [7:0] a);
        logic [7:0] r = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gf_mul(a, 8'(b)) == 8'h01) r = 8'(b);
        end
        return r;
    endfunction

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    // Stimulus helpers (no checking): present an operand until accepted.
    task automatic do_accept(input logic [7:0] a, input logic [7:0] e);
        in_data  = a;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(e);
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        logic [7:0] e;
        out_ready = 1'b1;
        do_accept(8'h53, 8'hCA);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy got %b want 1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL t1_in_ready_busy got %b want 0", in_ready); end
        wait_out(cyc);
        n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL t1_latency got %0d want %0d", cyc, LAT); end
        e = pop_exp();
        n_cmp++; if (out_data !== e) begin n_bad++; $display("FAIL t1_data got %h want %h", out_data, e); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_done got %b want 0", busy); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL t1_handshake got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] ins[4];
        logic [7:0] outs[4];
        int cyc;
        logic [7:0] e;
        ins  = '{8'h01, 8'h02, 8'h00, 8'hFF};
        outs = '{8'h01, 8'h8D, 8'h00, 8'h1C};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_accept(ins[k], outs[k]);
            wait_out(cyc);
            n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL t2_latency a=%h got %0d want %0d", ins[k], cyc, LAT); end
            e = pop_exp();
            n_cmp++; if (out_data !== e) begin n_bad++; $display("FAIL t2_data a=%h got %h want %h", ins[k], out_data, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exhaustive();
        int cyc;
        logic [7:0] e;
        logic [7:0] a;
        out_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            a = 8'(k);
            do_accept(a, gf_inv_model(a));
            wait_out(cyc);
            n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL t3_latency a=%h got %0d want %0d", a, cyc, LAT); end
            e = pop_exp();
            n_cmp++; if (out_data !== e) begin n_bad++; $display("FAIL t3_data a=%h got %h want %h", a, out_data, e); end
            if (a != 8'h00) begin
                n_cmp++; if (gf_mul(a, out_data) !== 8'h01) begin
                    n_bad++; $display("FAIL t3_product a=%h got %h want 01", a, gf_mul(a, out_data));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [7:0] e;
        out_ready = 1'b0;
        do_accept(8'h53, 8'hCA);
        wait_out(cyc);
        n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL t4_latency got %0d want %0d", cyc, LAT); end
        e = pop_exp();
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_data  = 8'(i * 13 + 7);
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL t4_hold cyc=%0d got valid=%b data=%h ready=%b want 1/%h/0",
                         i, out_valid, out_data, in_ready, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== e) begin
            n_bad++;
            $display("FAIL t4_release got valid=%b ready=%b data=%h want 0/1/%h", out_valid, in_ready, out_data, e);
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t4_ignored_in got busy=%b want 0", busy); end
    endtask

    task automatic test_async_reset();
        int cyc;
        logic [7:0] e;
        out_ready = 1'b1;
        in_data   = 8'h53;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t5_busy_pre got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_async got ready=%b valid=%b data=%h busy=%b want 1/0/00/0",
                     in_ready, out_valid, out_data, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t5_stale got %b want 0", out_valid); end
        do_accept(8'h53, 8'hCA);
        wait_out(cyc);
        n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL t5_latency got %0d want %0d", cyc, LAT); end
        e = pop_exp();
        n_cmp++; if (out_data !== e) begin n_bad++; $display("FAIL t5_data got %h want %h", out_data, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int gap;
        logic [7:0] e;
        out_ready = 1'b1;
        in_data   = 8'h53;
        in_valid  = 1'b1;
        for (int i = 0; i < 300 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        exp_q.push_back(8'hCA);
        in_data = 8'h02;
        exp_q.push_back(8'h8D);
        wait_out(cyc);
        n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL t6_latency1 got %0d want %0d", cyc, LAT); end
        e = pop_exp();
        n_cmp++; if (out_data !== e) begin n_bad++; $display("FAIL t6_data1 got %h want %h", out_data, e); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL t6_no_bypass got %b want 0", in_ready); end
        @(posedge clk); #1;  // output handshake edge
        gap = 0;
        while (gap < 10 && !in_ready) begin
            @(posedge clk); #1;
            gap++;
        end
        n_cmp++; if (gap !== 0) begin n_bad++; $display("FAIL t6_reaccept_gap got %0d want 0", gap); end
        @(posedge clk); #1;  // second accept edge
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t6_second_accept got busy=%b want 1", busy); end
        wait_out(cyc);
        n_cmp++; if (cyc !== LAT) begin n_bad++; $display("FAIL t6_latency2 got %0d want %0d", cyc, LAT); end
        e = pop_exp();
        n_cmp++; if (out_data !== e) begin n_bad++; $display("FAIL t6_data2 got %h want %h", out_data, e); end
        @(posedge clk); #1;
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL t6_queue_left got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_exhaustive();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
